// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive path: parity modes,
// transmitter FSM encoding and frame-length arithmetic.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    function automatic int frame_len(input int data_bits, input int parity_mode,
                                     input int stop_bits);
        return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_fifo_sync.sv
// Synchronous FIFO with occupancy count, shared by the UART transmit and receive paths.
// Pushes are ignored when full and pops are ignored when empty.
module uart_fifo_sync #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [DATA_W-1:0]       data_i,
    output logic [DATA_W-1:0]       data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_o == CNT_W'(DEPTH));
    assign empty_o = (count_o == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push && rst_ni) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + CNT_W'(1);
                2'b01:   count_o <= count_o - CNT_W'(1);
                default: count_o <= count_o;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Configurable-format UART transmitter: FIFO-buffered valid/ready input,
// LSB-first serialisation with optional parity and 1 or 2 stop bits.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         tick_i,
    input  logic                         valid_i,
    input  logic [DATA_BITS-1:0]         data_i,
    output logic                         ready_o,
    output logic                         txd_o,
    output logic                         busy_o,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_cnt_o
);

    localparam int FRAME_BITS = frame_len(DATA_BITS, PARITY_MODE, STOP_BITS);
    localparam int TICK_W     = $clog2(OVERSAMPLE);
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              HAS_PAR   = (PARITY_MODE != PARITY_NONE);
    localparam logic              ODD_PAR   = (PARITY_MODE == PARITY_ODD);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 4 || OVERSAMPLE > 32) begin : g_bad_oversample
        $error("uart_tx_frame: OVERSAMPLE must be 4..32");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_frame: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_e              state;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   head;
    logic                   parity_q;
    logic                   head_par;
    logic [TICK_W-1:0]      tick_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   bit_end;
    logic                   last_stop;
    logic                   pop;

    assign ready_o   = !fifo_full;
    assign busy_o    = (state != ST_IDLE);
    assign head_par  = (^head) ^ ODD_PAR;
    assign bit_end   = tick_i && (tick_cnt == TICK_LAST);
    assign last_stop = (state == ST_STOP) && bit_end && (bit_cnt == STOP_LAST);
    // Popping at the last stop-bit end chains frames with no idle gap.
    assign pop       = !fifo_empty && (((state == ST_IDLE) && tick_i) || last_stop);

    uart_fifo_sync #(
        .DATA_W (DATA_BITS),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (valid_i),
        .pop_i   (pop),
        .data_i  (data_i),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            txd_o    <= 1'b1;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if (pop) begin
            state    <= ST_START;
            txd_o    <= 1'b0;
            shift_q  <= head;
            parity_q <= head_par;
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if (state != ST_IDLE && tick_i) begin
            if (!bit_end) begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end else begin
                tick_cnt <= '0;
                case (state)
                    ST_START: begin
                        state <= ST_DATA;
                        txd_o <= shift_q[0];
                    end
                    ST_DATA: begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (HAS_PAR) begin
                                state <= ST_PARITY;
                                txd_o <= parity_q;
                            end else begin
                                state <= ST_STOP;
                                txd_o <= 1'b1;
                            end
                        end else begin
                            shift_q <= shift_q >> 1;
                            txd_o   <= shift_q[1];
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                    ST_PARITY: begin
                        state   <= ST_STOP;
                        txd_o   <= 1'b1;
                        bit_cnt <= '0;
                    end
                    ST_STOP: begin
                        if (bit_cnt == STOP_LAST) begin
                            state <= ST_IDLE;
                            txd_o <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        txd_o <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: an 8N1 instance plus 7E2 and 7O2 instances,
// ticked every 4 clocks so each bit spans 64 clocks.
module tb_uart_tx_frame;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       tick_en;
    int         div;

    logic       valid0;
    logic [7:0] data0;
    logic       ready0, txd0, busy0;
    logic [2:0] cnt0;

    logic       valid_p;
    logic [6:0] data_p;
    logic       ready1, txd1, busy1;
    logic [2:0] cnt1;
    logic       ready2, txd2, busy2;
    logic [2:0] cnt2;

    int         tests;
    int         fails;
    int         sel;
    logic       mon;
    logic [63:0] c0, c1, c2;
    bit         ok;

    assign mon = (sel == 1) ? txd1 : (sel == 2) ? txd2 : txd0;

    uart_tx_frame dut (
        .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .valid_i(valid0), .data_i(data0),
        .ready_o(ready0), .txd_o(txd0), .busy_o(busy0), .fifo_cnt_o(cnt0)
    );

    uart_tx_frame #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) dut_even (
        .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .valid_i(valid_p), .data_i(data_p),
        .ready_o(ready1), .txd_o(txd1), .busy_o(busy1), .fifo_cnt_o(cnt1)
    );

    uart_tx_frame #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) dut_odd (
        .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .valid_i(valid_p), .data_i(data_p),
        .ready_o(ready2), .txd_o(txd2), .busy_o(busy2), .fifo_cnt_o(cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle tick every fourth clock, changed on the falling edge.
    initial begin
        tick = 1'b0;
        div  = 0;
        forever begin
            @(negedge clk);
            div  = (div + 1) % 4;
            tick = tick_en && (div == 0);
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog");
    end

    // Waits for the selected line to drop, then samples every bit at mid-period.
    task automatic capture(input int nbits, output logic [63:0] b0, output logic [63:0] b1,
                           output logic [63:0] b2, output bit found);
        found = 1'b0;
        b0 = '1;
        b1 = '1;
        b2 = '1;
        for (int t = 0; t < 3000 && !found; t++) begin
            @(negedge clk);
            if (mon === 1'b0) found = 1'b1;
        end
        if (!found) return;
        repeat (32) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            b0[i] = txd0;
            b1[i] = txd1;
            b2[i] = txd2;
            if (i < nbits - 1) repeat (64) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int t = 0; t < 3000 && !idle; t++) begin
            @(negedge clk);
            idle = !busy0 && !busy1 && !busy2 && (cnt0 == 3'd0);
        end
        tests++;
        if (!idle) begin
            fails++;
            $display("[TB] FAIL wait_idle: got busy=%b%b%b cnt=%0d expected all idle", busy0, busy1, busy2, cnt0);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        valid0  = 1'b1;
        data0   = 8'hA5;
        valid_p = 1'b1;
        data_p  = 7'h07;
        tick_en = 1'b0;
        sel     = 0;
        repeat (3) @(negedge clk);
        tests++; if (txd0 !== 1'b1) begin fails++; $display("[TB] FAIL reset_txd: got %b expected 1", txd0); end
        tests++; if (ready0 !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 1", ready0); end
        tests++; if (cnt0 !== 3'd0) begin fails++; $display("[TB] FAIL reset_cnt: got %0d expected 0", cnt0); end
        tests++; if (busy0 !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy0); end
        rst_n   = 1'b1;
        valid0  = 1'b0;
        valid_p = 1'b0;
        @(negedge clk);
        tests++; if (cnt0 !== 3'd0 || cnt1 !== 3'd0) begin fails++; $display("[TB] FAIL reset_no_push: got %0d/%0d expected 0/0", cnt0, cnt1); end
    endtask

    task automatic test_8n1();
        sel    = 0;
        valid0 = 1'b1;
        data0  = 8'hA5;
        @(negedge clk);
        valid0  = 1'b0;
        tick_en = 1'b1;
        tests++; if (cnt0 !== 3'd1) begin fails++; $display("[TB] FAIL 8n1_push: got cnt %0d expected 1", cnt0); end
        capture(10, c0, c1, c2, ok);
        tests++;
        if (!ok || c0[9:0] !== 10'b1_10100101_0) begin
            fails++;
            $display("[TB] FAIL 8n1_frame: got %b (started %b) expected %b", c0[9:0], ok, 10'b1_10100101_0);
        end
        // The stop bit ends 32 clocks after its midpoint sample.
        repeat (31) @(negedge clk);
        tests++; if (busy0 !== 1'b1) begin fails++; $display("[TB] FAIL 8n1_busy_hold: got %b expected 1", busy0); end
        @(negedge clk);
        tests++; if (busy0 !== 1'b0 || txd0 !== 1'b1) begin fails++; $display("[TB] FAIL 8n1_busy_drop: got busy %b txd %b expected 0 1", busy0, txd0); end
        wait_idle();
    endtask

    task automatic test_parity();
        sel     = 1;
        valid_p = 1'b1;
        data_p  = 7'h07;
        @(negedge clk);
        valid_p = 1'b0;
        capture(11, c0, c1, c2, ok);
        tests++;
        if (!ok || c1[10:0] !== 11'b111_0000111_0) begin
            fails++;
            $display("[TB] FAIL 7e2_frame: got %b (started %b) expected %b", c1[10:0], ok, 11'b111_0000111_0);
        end
        tests++;
        if (!ok || c2[10:0] !== 11'b110_0000111_0) begin
            fails++;
            $display("[TB] FAIL 7o2_frame: got %b (started %b) expected %b", c2[10:0], ok, 11'b110_0000111_0);
        end
        sel = 0;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        tick_en = 1'b0;
        sel     = 0;
        @(negedge clk);
        valid0 = 1'b1;
        data0  = 8'h55;
        @(negedge clk);
        data0  = 8'hAA;
        @(negedge clk);
        data0  = 8'h0F;
        @(negedge clk);
        valid0 = 1'b0;
        tests++; if (cnt0 !== 3'd3) begin fails++; $display("[TB] FAIL b2b_cnt: got %0d expected 3", cnt0); end
        tick_en = 1'b1;
        capture(30, c0, c1, c2, ok);
        tests++;
        if (!ok || c0[29:0] !== 30'b1_00001111_0_1_10101010_0_1_01010101_0) begin
            fails++;
            $display("[TB] FAIL b2b_frames: got %b (started %b) expected %b", c0[29:0], ok,
                     30'b1_00001111_0_1_10101010_0_1_01010101_0);
        end
        wait_idle();
    endtask

    task automatic test_fifo_full();
        logic [7:0] w [5];
        logic [49:0] exp_bits;
        int   k;
        bit   acc;
        bit   got;
        logic [2:0] seen_cnt;
        w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44; w[4] = 8'h81;
        exp_bits = {1'b1, 8'h81, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 8'h33, 1'b0,
                    1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0};
        tick_en  = 1'b0;
        sel      = 0;
        k        = 0;
        seen_cnt = '0;
        got      = 1'b0;
        @(negedge clk);
        fork
            capture(50, c0, c1, c2, ok);
            begin
                for (int i = 0; i < 8; i++) begin
                    valid0 = 1'b1;
                    data0  = w[k];
                    acc    = ready0;
                    @(negedge clk);
                    if (acc) k++;
                end
                tests++; if (k != 4) begin fails++; $display("[TB] FAIL full_accepted: got %0d expected 4", k); end
                tests++; if (ready0 !== 1'b0) begin fails++; $display("[TB] FAIL full_ready: got %b expected 0", ready0); end
                tests++; if (cnt0 !== 3'd4) begin fails++; $display("[TB] FAIL full_cnt: got %0d expected 4", cnt0); end
                tick_en = 1'b1;
                data0   = w[4];
                for (int i = 0; i < 20 && !got; i++) begin
                    if (ready0 === 1'b1) begin
                        seen_cnt = cnt0;
                        got      = 1'b1;
                    end
                    @(negedge clk);
                end
                valid0 = 1'b0;
                tests++; if (!got) begin fails++; $display("[TB] FAIL full_reopen: got ready 0 expected 1 within 20 cycles"); end
                tests++; if (seen_cnt !== 3'd3) begin fails++; $display("[TB] FAIL full_reopen_cnt: got %0d expected 3", seen_cnt); end
                tests++; if (cnt0 !== 3'd4) begin fails++; $display("[TB] FAIL full_fifth_push: got %0d expected 4", cnt0); end
            end
        join
        tests++;
        if (!ok || c0[49:0] !== exp_bits) begin
            fails++;
            $display("[TB] FAIL full_order: got %b (started %b) expected %b", c0[49:0], ok, exp_bits);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        bit fell;
        tick_en = 1'b1;
        sel     = 0;
        valid0  = 1'b1;
        data0   = 8'hC3;
        @(negedge clk);
        data0   = 8'h99;
        @(negedge clk);
        valid0  = 1'b0;
        fell    = 1'b0;
        for (int t = 0; t < 3000 && !fell; t++) begin
            @(negedge clk);
            if (txd0 === 1'b0) fell = 1'b1;
        end
        tests++; if (!fell) begin fails++; $display("[TB] FAIL mid_start: got no start bit expected one"); end
        repeat (32 + 64 * 4) @(negedge clk);
        tests++; if (txd0 !== 1'b0 || busy0 !== 1'b1) begin fails++; $display("[TB] FAIL mid_bit3: got txd %b busy %b expected 0 1", txd0, busy0); end
        rst_n = 1'b0;
        @(negedge clk);
        tests++; if (txd0 !== 1'b1) begin fails++; $display("[TB] FAIL mid_rst_txd: got %b expected 1", txd0); end
        tests++; if (cnt0 !== 3'd0) begin fails++; $display("[TB] FAIL mid_rst_cnt: got %0d expected 0", cnt0); end
        tests++; if (busy0 !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_busy: got %b expected 0", busy0); end
        rst_n = 1'b1;
        fell  = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (txd0 !== 1'b1) fell = 1'b1;
        end
        tests++; if (fell) begin fails++; $display("[TB] FAIL mid_no_resend: got line activity expected idle high"); end
        valid0 = 1'b1;
        data0  = 8'h3C;
        @(negedge clk);
        valid0 = 1'b0;
        capture(10, c0, c1, c2, ok);
        tests++;
        if (!ok || c0[9:0] !== 10'b1_00111100_0) begin
            fails++;
            $display("[TB] FAIL mid_clean_frame: got %b (started %b) expected %b", c0[9:0], ok, 10'b1_00111100_0);
        end
        wait_idle();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter that supersedes the single-format 8N1 transmitter in the UART path. It accepts words over a valid/ready handshake into a small internal FIFO and serialises them LSB-first on txd_o. Frame format is selectable: 5–9 data bits, none/even/odd parity, 1 or 2 stop bits. It sits between the user data source and the pad, driven by the shared baud tick generator (tick_i at OVERSAMPLE × baud).

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_MODE, 0, parity selection: 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
OVERSAMPLE, 16, tick_i pulses per bit period; legal range 4..32.
FIFO_DEPTH, 4, input FIFO entries; power of two, ≥2.

Ports:
clk_i  in  1  system clock, all logic on rising edge.
rst_ni  in  1  synchronous reset, active-low.
tick_i  in  1  one-cycle oversample strobe from the baud generator.
valid_i  in  1  data_i holds a word to enqueue.
data_i  in  DATA_BITS  word to transmit; bit 0 is sent first.
ready_o  out  1  FIFO can accept; a push occurs when valid_i && ready_o.
txd_o  out  1  serial line, idle high, registered.
busy_o  out  1  a frame is in progress (state ≠ IDLE).
fifo_cnt_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_ni=0 at a clock edge): txd_o=1, busy_o=0, ready_o=1, fifo_cnt_o=0, FIFO emptied, state IDLE, tick and bit counters cleared. Reset mid-frame aborts the frame; the line returns high on the next edge; the lost word is not retransmitted.
- FIFO push: ready_o = (count < FIFO_DEPTH), derived from the registered count.
  - Push and pop in the same cycle: count unchanged.
  - When full, a same-cycle pop does not make ready_o high in that cycle.
  - A pushed word becomes visible to the FSM on the next cycle.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
  - IDLE: txd_o=1. On a cycle with tick_i=1 and the FIFO non-empty, pop the head into the shift register, compute parity, clear counters, and go to START. txd_o=0 from the next edge.
  - Bit timing: each bit holds for exactly OVERSAMPLE ticks. The tick counter increments on tick_i. When the counter is at OVERSAMPLE-1 and tick_i=1, the bit ends, the counter wraps to 0, and the next bit appears on txd_o at the following edge.
  - START: drive 0 for one bit, then go to DATA.
  - DATA: drive shift[0]; shift right at each bit end. After DATA_BITS bits, go to PARITY if PARITY_MODE≠0, else STOP.
  - PARITY: even = XOR of all data bits; odd = its inverse. One bit, then go to STOP.
  - STOP: drive 1 for STOP_BITS bits. At the final stop-bit end:
    - FIFO non-empty: pop and go directly to START, so back-to-back frames have no idle gap.
    - Otherwise go to IDLE.
- Frame length = 1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS bits. All counters use $clog2-sized widths with no overflow.
- tick_i pulses while in IDLE with an empty FIFO are ignored. A tick_i held high for consecutive cycles counts once per cycle.
- Illegal parameter values are trapped by elaboration-time assertions (simulation only).

Decomposition:
- Shared package uart_pkg holds:
  - PARITY_NONE/EVEN/ODD constants.
  - FSM state encoding (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP).
  - A frame-length function.
- One sub-module: uart_fifo_sync (DATA_W, DEPTH) — synchronous FIFO with push/pop/full/empty/count. The same FIFO is reusable on the receive side.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles with valid_i=1 → txd_o=1, ready_o=1, fifo_cnt_o=0, busy_o=0; no word accepted.
- 8N1: push 0xA5, tick every 4 clocks → txd_o sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop). Each bit lasts 16 ticks (64 clocks); busy_o drops after the stop bit.
- 7E2 (DATA_BITS=7, PARITY_MODE=1, STOP_BITS=2): push 0x07 → data 1,1,1,0,0,0,0, parity 1, stop 1,1. With PARITY_MODE=2 the parity bit = 0.
- Back-to-back: push 0x55, 0xAA, 0x0F in consecutive cycles → three 10-bit frames with the stop bit followed directly by the next start bit; no extra idle ticks.
- FIFO full (FIFO_DEPTH=4): hold valid_i=1 while IDLE with tick_i=0 → 4 words accepted, ready_o=0, fifo_cnt_o=4. Enable ticks → after the first pop ready_o=1 and the 5th word is accepted. The transmit order matches the push order.
- Reset mid-frame: deassert rst_ni during DATA bit 3 → txd_o=1 on the next edge, FIFO empty. After release, push 0x3C → a clean full frame is sent.
